speech_source_mc: RTL



---
 rtl/speech_source_mc.sv | 102 ++++++++++
 1 files changed

// File: rtl/speech_source_mc.sv
// speech_source_mc: excitation source for the Speech256 filter cascade.
//   Produces a pitch pulse train, LFSR white noise or a mix of both, scaled
//   by a signed amplitude, one sample per strobe (output latency 1 clk).
//   Period and mode are latched only at pitch-period boundaries.
// Ports:
//   clk         system clock
//   rst_an      asynchronous active-low reset
//   strobe      one-cycle sample enable
//   period      pitch period in samples (0 = unvoiced in AUTO mode)
//   mode        00 AUTO, 01 PULSE, 10 NOISE, 11 MIXED
//   amplitude   signed excitation amplitude
//   period_done one-clk pulse on the strobe that ends a pitch period
//   source_out  signed excitation sample
// Optional: define SPEECH_SRC_SLEW_EN to slew-limit the amplitude by AMP_STEP
//   per strobe.
module speech_source_mc #(
    parameter int          PER_W     = 8,
    parameter int          AMP_W     = 15,
    parameter int          OUT_W     = 16,
    parameter logic [16:0] LFSR_SEED = 17'h00001,
    parameter int          AMP_STEP  = 64
) (
    input  logic                    clk,
    input  logic                    rst_an,
    input  logic                    strobe,
    input  logic [PER_W-1:0]        period,
    input  logic [1:0]              mode,
    input  logic signed [AMP_W-1:0] amplitude,
    output logic                    period_done,
    output logic signed [OUT_W-1:0] source_out
);
    typedef enum logic [1:0] {AUTO = 2'b00, PULSE = 2'b01, NOISE = 2'b10, MIXED = 2'b11} mode_t;

    logic [PER_W-1:0]        pcnt, per_q, per_cur, per_eff;
    mode_t                   mode_q, mode_cur, mode_eff;
    logic [16:0]             lfsr;
    logic                    started, wrap;
    logic signed [OUT_W-1:0] amp_eff, pulse_c, noise_c, sample;

`ifdef SPEECH_SRC_SLEW_EN
    localparam logic signed [AMP_W:0] STEP = (AMP_W+1)'(AMP_STEP);
    logic signed [AMP_W-1:0] amp_q, amp_nxt;
    logic signed [AMP_W:0]   diff;
    // The slewed value for this strobe is used immediately, so the first
    // pulse after a step already carries one AMP_STEP of movement.
    always_comb begin
        diff    = (AMP_W+1)'(amplitude) - (AMP_W+1)'(amp_q);
        amp_nxt = diff > STEP ? amp_q + AMP_W'(AMP_STEP) :
                  diff < -STEP ? amp_q - AMP_W'(AMP_STEP) : amplitude;
    end
    assign amp_eff = OUT_W'(amp_nxt);
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an)
            amp_q <= '0;
        else if (strobe)
            amp_q <= amp_nxt;
    end
`else
    // AMP_STEP only matters when slewing is built in.
    logic unused_amp_step;
    assign unused_amp_step = (AMP_STEP > 0);
    assign amp_eff = OUT_W'(amplitude);
`endif

    always_comb begin
        // Before the first strobe nothing is latched yet, so the live inputs apply.
        per_cur  = started ? per_q : period;
        mode_cur = started ? mode_q : mode_t'(mode);
        per_eff  = (per_cur == '0) ? PER_W'(1) : per_cur;
        mode_eff = (mode_cur != AUTO) ? mode_cur : (per_cur == '0) ? NOISE : PULSE;
        wrap     = pcnt >= per_eff - PER_W'(1);
        pulse_c  = (pcnt == '0) ? amp_eff : '0;
        noise_c  = lfsr[0] ? amp_eff : -amp_eff;
        sample   = mode_eff == PULSE ? pulse_c :
                   mode_eff == NOISE ? noise_c : pulse_c + (noise_c >>> 2);
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            source_out  <= '0;
            period_done <= 1'b0;
            pcnt        <= '0;
            per_q       <= '0;
            mode_q      <= AUTO;
            lfsr        <= LFSR_SEED;
            started     <= 1'b0;
        end else begin
            period_done <= 1'b0;
            if (strobe) begin
                started     <= 1'b1;
                source_out  <= sample;
                period_done <= wrap;
                lfsr        <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
                pcnt        <= wrap ? '0 : pcnt + PER_W'(1);
                if (wrap || !started) begin
                    per_q  <= period;
                    mode_q <= mode_t'(mode);
                end
            end
        end
    end
endmodule
